ram_based_shift_reg: RTL and testbench



---
 rtl/ram_based_shift_reg.sv | 76 +++++++
 tb/tb_ram_based_shift_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ram_based_shift_reg.sv
// ============================================================================
// Module      : ram_based_shift_reg
// Description : Fixed-length delay line built from a circular RAM buffer plus
//               one output register. Optional shift enable via RAM_SHIFT_CE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_based_shift_reg #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
`ifdef RAM_SHIFT_CE_EN
  input  logic             CE,
`endif
  input  logic [DSIZE-1:0] Din,
  output logic [DSIZE-1:0] Q
);

  // DEPTH-1 words live in RAM; the output register supplies the last stage.
  localparam int c_WORDS = DEPTH - 1;
  localparam int c_AW    = (c_WORDS <= 2) ? 1 : $clog2(c_WORDS);
  localparam int c_FW    = $clog2(DEPTH);

  localparam logic [c_AW-1:0] c_PTR_LAST  = c_AW'(c_WORDS - 1);
  localparam logic [c_FW-1:0] c_FILL_FULL = c_FW'(DEPTH - 1);

  logic [DSIZE-1:0] r_mem [0:c_WORDS-1];
  logic [c_AW-1:0]  r_ptr;
  logic [c_FW-1:0]  r_fill;
  logic [DSIZE-1:0] r_q;
  logic [DSIZE-1:0] w_ram_rd;
  logic             w_accept;
  logic             w_full;

`ifdef RAM_SHIFT_CE_EN
  assign w_accept = CE;
`else
  assign w_accept = 1'b1;
`endif

  assign w_ram_rd = r_mem[r_ptr];
  assign w_full   = (r_fill == c_FILL_FULL);
  assign Q        = r_q;

  // Storage carries no reset: until the buffer has been written once, the
  // fill counter masks whatever the RAM powered up with.
  always_ff @(posedge Clock) begin
    if (w_accept && !Reset) begin
      r_mem[r_ptr] <= Din;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ptr  <= '0;
      r_fill <= '0;
      r_q    <= '0;
    end else if (w_accept) begin
      r_q <= w_full ? w_ram_rd : '0;
      if (r_ptr == c_PTR_LAST) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (!w_full) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_based_shift_reg.sv
// ============================================================================
// Module      : tb_ram_based_shift_reg
// Description : Self-checking bench for ram_based_shift_reg at several depths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_based_shift_reg;

`ifdef RAM_SHIFT_CE_EN
  localparam bit c_HAS_CE = 1'b1;
`else
  localparam bit c_HAS_CE = 1'b0;
`endif

  logic       Clock;
  logic       Reset;
  logic       ce;
  logic [7:0] din;
  logic [7:0] q4, q2, q3, q5, q17;

  int tests_run;
  int tests_failed;

  // History of every word accepted since the last reset.
  logic [7:0] hist[$];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  ram_based_shift_reg #(.DSIZE(8), .DEPTH(4)) u_d4 (
    .Clock(Clock), .Reset(Reset),
`ifdef RAM_SHIFT_CE_EN
    .CE(ce),
`endif
    .Din(din), .Q(q4));
  ram_based_shift_reg #(.DSIZE(8), .DEPTH(2)) u_d2 (
    .Clock(Clock), .Reset(Reset),
`ifdef RAM_SHIFT_CE_EN
    .CE(ce),
`endif
    .Din(din), .Q(q2));
  ram_based_shift_reg #(.DSIZE(8), .DEPTH(3)) u_d3 (
    .Clock(Clock), .Reset(Reset),
`ifdef RAM_SHIFT_CE_EN
    .CE(ce),
`endif
    .Din(din), .Q(q3));
  ram_based_shift_reg #(.DSIZE(8), .DEPTH(5)) u_d5 (
    .Clock(Clock), .Reset(Reset),
`ifdef RAM_SHIFT_CE_EN
    .CE(ce),
`endif
    .Din(din), .Q(q5));
  ram_based_shift_reg #(.DSIZE(8), .DEPTH(17)) u_d17 (
    .Clock(Clock), .Reset(Reset),
`ifdef RAM_SHIFT_CE_EN
    .CE(ce),
`endif
    .Din(din), .Q(q17));

  // After n accepted words the delay line of length d shows word n-d (0-based).
  function automatic logic [7:0] model_q(int d);
    int n;
    n = hist.size();
    if (n >= d) return hist[n - d];
    return 8'h00;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%02h expected=%02h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "_d4"},  q4,  model_q(4));
    check({tag, "_d2"},  q2,  model_q(2));
    check({tag, "_d3"},  q3,  model_q(3));
    check({tag, "_d5"},  q5,  model_q(5));
    check({tag, "_d17"}, q17, model_q(17));
  endtask

  // Present d/c, take one rising edge, update the model, check 1 time unit later.
  task automatic do_edge(input logic [7:0] d, input logic c, input string tag);
    din = d;
    ce  = c;
    @(posedge Clock);
    if (!Reset && (!c_HAS_CE || c)) hist.push_back(d);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic pulse_reset(input int cycles);
    #2;
    Reset = 1'b1;
    #1;
    hist.delete();
    check_all("async_rst");
    for (int i = 0; i < cycles; i++) begin
      din = 8'($urandom);
      @(posedge Clock);
      #1;
      check_all("rst_held");
    end
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    logic [7:0] cnt;
    tests_run    = 0;
    tests_failed = 0;
    Reset = 1'b1;
    ce    = 1'b1;
    din   = 8'h00;
    #1;
    check_all("por");
    #10;
    Reset = 1'b0;

    // Load every RAM with 0xFF so stale data would show during the next fill.
    for (int i = 0; i < 40; i++) do_edge(8'hFF, 1'b1, "prefill");
    pulse_reset(2);

    // Directed ramp 1,2,3...: Q is zero for three edges, then Din-3.
    for (int k = 1; k <= 20; k++) begin
      do_edge(8'(k), 1'b1, "ramp");
      check("ramp_explicit_d4", q4, (k >= 4) ? 8'(k - 3) : 8'h00);
    end
    pulse_reset(1);

    // Free-running counter with a 100 ns reset partway through.
    cnt = 8'h00;
    for (int i = 0; i < 5000; i++) begin
      if (i == 300) pulse_reset(10);
      do_edge(cnt, 1'b1, "count");
      cnt = cnt + 8'd1;
    end

    // Random data; shift enable randomised when present.
    for (int i = 0; i < 2000; i++) begin
      do_edge(8'($urandom), c_HAS_CE ? 1'($urandom_range(0, 1)) : 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
